writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 21 ++
 rtl/writeback_arbiter_if.sv | 40 ++++
 rtl/writeback_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared CPU constants and types used by the writeback arbiter.
// Register-file address width and the hard-wired zero register live here.
package writeback_arbiter_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = '0;

  // Width of the requester-1 starvation counter (limit range 1..15).
  localparam int unsigned STARVE_CNT_WIDTH = 4;

  typedef enum logic {
    GrantReq0 = 1'b0,
    GrantReq1 = 1'b1
  } grant_e;

  // Register-file strobe: a write to x0 is swallowed.
  function automatic logic wb_strobe(input logic we, input logic [REG_ADDR_WIDTH-1:0] dest);
    return we && (dest != REG_X0);
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Requester handshakes plus register-file write port of the writeback arbiter.
// master = requesters / register file side, slave = arbiter.
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
);

  logic                      req0_valid;
  logic                      req0_ready;
  logic [WORD_SIZE-1:0]      req0_data;
  logic [REG_ADDR_WIDTH-1:0] req0_dest;
  logic                      req0_we;

  logic                      req1_valid;
  logic                      req1_ready;
  logic [WORD_SIZE-1:0]      req1_data;
  logic [REG_ADDR_WIDTH-1:0] req1_dest;
  logic                      req1_we;

  logic [WORD_SIZE-1:0]      write_data;
  logic [REG_ADDR_WIDTH-1:0] write_addr;
  logic                      write_enable_out;
  logic                      grant_id;

  modport master (
    output req0_valid, req0_data, req0_dest, req0_we,
    output req1_valid, req1_data, req1_dest, req1_we,
    input  req0_ready, req1_ready,
    input  write_data, write_addr, write_enable_out, grant_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_dest, req0_we,
    input  req1_valid, req1_data, req1_dest, req1_we,
    output req0_ready, req1_ready,
    output write_data, write_addr, write_enable_out, grant_id
  );

endinterface

// File: rtl/writeback_arbiter.sv
// Two-requester writeback arbiter: requester 0 has priority, requester 1 is
// forced through after STARVE_LIMIT consecutive lost cycles. Payload is registered.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clock,
  input logic               reset_n,
  input logic               stall,
  writeback_arbiter_if.slave bus
);

  localparam logic [STARVE_CNT_WIDTH-1:0] StarveMax = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  logic [STARVE_CNT_WIDTH-1:0] r_starve_cnt;
  logic [WORD_SIZE-1:0]        r_write_data;
  logic [REG_ADDR_WIDTH-1:0]   r_write_addr;
  logic                        r_write_enable;
  grant_e                      r_grant_id;

  logic                        w_run;
  logic                        w_starved;
  logic                        w_grant0;
  logic                        w_grant1;
  logic                        w_xfer0;
  logic                        w_xfer1;
  logic [WORD_SIZE-1:0]        w_sel_data;
  logic [REG_ADDR_WIDTH-1:0]   w_sel_dest;
  logic                        w_sel_we;

  // Readies depend only on valids, stall, reset and the counter, never on each other.
  always_comb begin
    w_run     = reset_n && !stall;
    w_starved = (r_starve_cnt == StarveMax);
    w_grant1  = bus.req1_valid && (!bus.req0_valid || w_starved);
    w_grant0  = bus.req0_valid && !w_grant1;
    w_xfer0   = w_run && w_grant0;
    w_xfer1   = w_run && w_grant1;
  end

  assign bus.req0_ready = w_xfer0;
  assign bus.req1_ready = w_xfer1;

  always_comb begin
    w_sel_data = bus.req0_data;
    w_sel_dest = bus.req0_dest;
    w_sel_we   = bus.req0_we;
    if (w_xfer1) begin
      w_sel_data = bus.req1_data;
      w_sel_dest = bus.req1_dest;
      w_sel_we   = bus.req1_we;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_write_data   <= '0;
      r_write_addr   <= '0;
      r_write_enable <= 1'b0;
      r_grant_id     <= GrantReq0;
    end else begin
      r_write_enable <= 1'b0;
      if (w_xfer0 || w_xfer1) begin
        r_write_data   <= w_sel_data;
        r_write_addr   <= w_sel_dest;
        r_write_enable <= wb_strobe(w_sel_we, w_sel_dest);
        r_grant_id     <= w_xfer1 ? GrantReq1 : GrantReq0;
      end
    end
  end

  // Counts cycles requester 1 waited while arbitration was live; saturates at the limit.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (w_xfer1) begin
      r_starve_cnt <= '0;
    end else if (bus.req1_valid && !stall && (r_starve_cnt < StarveMax)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign bus.write_data       = r_write_data;
  assign bus.write_addr       = r_write_addr;
  assign bus.write_enable_out = r_write_enable;
  assign bus.grant_id         = r_grant_id;

endmodule
